fetch_stage: RTL

Instruction-fetch stage of the 32-bit MIPS pipeline. It is the consumer of the hazard unit's fetch/decode stall and branch-redirect outputs. It owns PCF, issues one-at-a-time requests to instruction memory over a req/ready + rvalid interface, and writes the IF/ID pipeline register. Stalls hold the register. Redirects flush it and discard any in-flight or held fetch. Delivers one instruction per cycle with a zero-wait memory.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS pipeline stages.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,   // ready to issue a request for PCF
      FETCH_WAIT = 2'd1,   // one request accepted, response outstanding
      FETCH_HOLD = 2'd2    // response captured while decode was stalled
   } fetch_state_t;

   // Instruction inserted into IF/ID for a bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Byte distance between sequential instructions
   localparam int unsigned PC_INCR = 4;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns PCF, issues one outstanding
//                request at a time to instruction memory, buffers a response
//                that arrives while decode is stalled, and writes the IF/ID
//                pipeline register. Branch redirects flush IF/ID and drop any
//                in-flight or held fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             PCSrcD,
   input  logic [WIDTH-1:0] PCBranchD,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] InstrD,
   output logic [WIDTH-1:0] PCPlus4D,
   output logic             ValidD
);

   localparam logic [WIDTH-1:0] c_PC_STEP    = WIDTH'(PC_INCR);
   localparam logic [WIDTH-1:0] c_ALIGN_MASK = ~(c_PC_STEP - WIDTH'(1));
   localparam logic [WIDTH-1:0] c_NOP        = WIDTH'(NOP_INSTR);

   // Sequencer and fetch-side state
   fetch_state_t     r_state;
   fetch_state_t     w_stateNext;
   logic [WIDTH-1:0] r_pcF;
   logic [WIDTH-1:0] w_pcFNext;
   logic             r_kill;
   logic             w_killNext;
   // The held word always belongs to PCF (PCF does not move while holding),
   // so the buffer's PC is PCF itself and needs no separate register.
   logic [WIDTH-1:0] r_holdInstr;
   logic [WIDTH-1:0] w_holdInstrNext;

   // IF/ID pipeline register
   logic [WIDTH-1:0] r_instrD;
   logic [WIDTH-1:0] w_instrDNext;
   logic [WIDTH-1:0] r_pcPlus4D;
   logic [WIDTH-1:0] w_pcPlus4DNext;
   logic             r_validD;
   logic             w_validDNext;

   // Request-side combinational signals
   logic             w_req;
   logic [WIDTH-1:0] w_addr;
   logic [WIDTH-1:0] w_pcPlus4F;
   logic [WIDTH-1:0] w_branchTarget;
   logic             w_redirect;

   // A redirect seen while decode is stalled is re-presented by the hazard
   // unit once the stall drops, so it is only acted on with StallD low.
   assign w_redirect     = PCSrcD & ~StallD;
   assign w_pcPlus4F     = r_pcF + c_PC_STEP;
   assign w_branchTarget = PCBranchD & c_ALIGN_MASK;

   // Next-state, PC, hold buffer, IF/ID and memory request decode
   always_comb begin
      w_stateNext     = r_state;
      w_pcFNext       = r_pcF;
      w_killNext      = r_kill;
      w_holdInstrNext = r_holdInstr;
      w_req           = 1'b0;
      w_addr          = r_pcF;
      // Nothing delivered: bubble when decode advances, hold when stalled
      if (StallD) begin
         w_instrDNext   = r_instrD;
         w_pcPlus4DNext = r_pcPlus4D;
         w_validDNext   = r_validD;
      end else begin
         w_instrDNext   = c_NOP;
         w_pcPlus4DNext = r_pcPlus4D;
         w_validDNext   = 1'b0;
      end

      case (r_state)
         FETCH_REQ: begin
            if (w_redirect) begin
               // Pending request for the old path is abandoned, not issued
               w_pcFNext = w_branchTarget;
            end else begin
               w_req = ~StallF;
               if (w_req && imem_ready) begin
                  w_stateNext = FETCH_WAIT;
               end
            end
         end

         FETCH_WAIT: begin
            if (w_redirect) begin
               w_pcFNext = w_branchTarget;
               if (imem_rvalid) begin
                  // Response is from the wrong path; nothing left in flight
                  w_killNext  = 1'b0;
                  w_stateNext = FETCH_REQ;
               end else begin
                  // Response still coming; drop it when it arrives
                  w_killNext = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (r_kill) begin
                  w_killNext  = 1'b0;
                  w_stateNext = FETCH_REQ;
               end else if (StallD) begin
                  w_holdInstrNext = imem_rdata;
                  w_stateNext     = FETCH_HOLD;
               end else begin
                  // Deliver and overlap the next request for back-to-back fetch
                  w_instrDNext   = imem_rdata;
                  w_pcPlus4DNext = w_pcPlus4F;
                  w_validDNext   = 1'b1;
                  w_pcFNext      = w_pcPlus4F;
                  w_addr         = w_pcPlus4F;
                  w_req          = ~StallF;
                  if (w_req && imem_ready) begin
                     w_stateNext = FETCH_WAIT;
                  end else begin
                     w_stateNext = FETCH_REQ;
                  end
               end
            end
         end

         FETCH_HOLD: begin
            if (w_redirect) begin
               w_pcFNext   = w_branchTarget;
               w_stateNext = FETCH_REQ;
            end else if (!StallD) begin
               w_instrDNext   = r_holdInstr;
               w_pcPlus4DNext = w_pcPlus4F;
               w_validDNext   = 1'b1;
               w_pcFNext      = w_pcPlus4F;
               w_stateNext    = FETCH_REQ;
            end
         end

         default: begin
            w_stateNext = FETCH_REQ;
            w_killNext  = 1'b0;
         end
      endcase
   end

   // Fetch-side state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FETCH_REQ;
         r_pcF       <= RESET_PC;
         r_kill      <= 1'b0;
         r_holdInstr <= c_NOP;
      end else begin
         r_state     <= w_stateNext;
         r_pcF       <= w_pcFNext;
         r_kill      <= w_killNext;
         r_holdInstr <= w_holdInstrNext;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instrD   <= c_NOP;
         r_pcPlus4D <= '0;
         r_validD   <= 1'b0;
      end else begin
         r_instrD   <= w_instrDNext;
         r_pcPlus4D <= w_pcPlus4DNext;
         r_validD   <= w_validDNext;
      end
   end

   // No request may escape while reset is held; address is always word aligned
   assign imem_req  = w_req & rst_n;
   assign imem_addr = w_addr & c_ALIGN_MASK;
   assign InstrD    = r_instrD;
   assign PCPlus4D  = r_pcPlus4D;
   assign ValidD    = r_validD;

endmodule : fetch_stage
`default_nettype wire
